// File: rtl/branch_resolve_unit_if.sv
// Request/result handshake bundle for the branch resolution stage.
// The unit sits on the slave side; the issuing/consuming logic sits on the master side.
interface branch_resolve_unit_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [XLEN-1:0]  opr_a_i;
    logic [XLEN-1:0]  opr_b_i;
    logic [XLEN-1:0]  pc_i;
    logic [XLEN-1:0]  imm_i;
    logic             is_b_type_i;
    logic [2:0]       instr_funct3_i;
    logic             pred_taken_i;
    logic [XLEN-1:0]  pred_target_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             branch_taken_o;
    logic             redirect_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic             misalign_o;
    logic             flush_i;
    logic             cnt_clr_i;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    modport master (
        output in_valid_i, opr_a_i, opr_b_i, pc_i, imm_i, is_b_type_i,
               instr_funct3_i, pred_taken_i, pred_target_i, out_ready_i,
               flush_i, cnt_clr_i,
        input  in_ready_o, out_valid_o, branch_taken_o, redirect_o,
               redirect_pc_o, misalign_o, branch_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  in_valid_i, opr_a_i, opr_b_i, pc_i, imm_i, is_b_type_i,
               instr_funct3_i, pred_taken_i, pred_target_i, out_ready_i,
               flush_i, cnt_clr_i,
        output in_ready_o, out_valid_o, branch_taken_o, redirect_o,
               redirect_pc_o, misalign_o, branch_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches, checks the prediction and issues redirects; keeps stats counters.
// Latency STAGES cycles (1 or 2) from accept edge to registered result.
// Valid/ready backpressure, each stage advances when empty or downstream advances; in_ready combinational from out_ready.
module branch_resolve_unit #(
    parameter int XLEN   = 64,
    parameter int STAGES = 1,
    parameter int CNT_W  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    branch_resolve_unit_if.slave  bus
);

    if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
        $error("branch_resolve_unit: STAGES must be 1 or 2");
    end

    logic            in_eq, in_lt, in_ltu;
    logic [XLEN-1:0] in_target;

    assign in_eq     = (bus.opr_a_i == bus.opr_b_i);
    assign in_lt     = ($signed(bus.opr_a_i) < $signed(bus.opr_b_i));
    assign in_ltu    = (bus.opr_a_i < bus.opr_b_i);
    assign in_target = bus.pc_i + bus.imm_i;

    // Entry presented to the final (output) stage.
    logic            s_vld, s_eq, s_lt, s_ltu, s_is_b, s_pred_taken;
    logic [2:0]      s_f3;
    logic [XLEN-1:0] s_pc, s_target, s_pred_target;

    logic out_vld, out_rdy, in_rdy, out_load;
    assign out_rdy = !out_vld || bus.out_ready_i;

    if (STAGES == 2) begin : g_two
        logic            a_vld, a_eq, a_lt, a_ltu, a_is_b, a_pred_taken;
        logic [2:0]      a_f3;
        logic [XLEN-1:0] a_pc, a_target, a_pred_target;

        assign in_rdy = !bus.flush_i && !rst_i && (!a_vld || out_rdy);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                a_vld         <= 1'b0;
                a_eq          <= 1'b0;
                a_lt          <= 1'b0;
                a_ltu         <= 1'b0;
                a_is_b        <= 1'b0;
                a_pred_taken  <= 1'b0;
                a_f3          <= 3'b000;
                a_pc          <= '0;
                a_target      <= '0;
                a_pred_target <= '0;
            end else if (bus.flush_i) begin
                a_vld <= 1'b0;
            end else if (!a_vld || out_rdy) begin
                a_vld <= bus.in_valid_i;
                if (bus.in_valid_i) begin
                    a_eq          <= in_eq;
                    a_lt          <= in_lt;
                    a_ltu         <= in_ltu;
                    a_is_b        <= bus.is_b_type_i;
                    a_pred_taken  <= bus.pred_taken_i;
                    a_f3          <= bus.instr_funct3_i;
                    a_pc          <= bus.pc_i;
                    a_target      <= in_target;
                    a_pred_target <= bus.pred_target_i;
                end
            end
        end

        assign s_vld         = a_vld;
        assign s_eq          = a_eq;
        assign s_lt          = a_lt;
        assign s_ltu         = a_ltu;
        assign s_is_b        = a_is_b;
        assign s_pred_taken  = a_pred_taken;
        assign s_f3          = a_f3;
        assign s_pc          = a_pc;
        assign s_target      = a_target;
        assign s_pred_target = a_pred_target;
        assign out_load      = a_vld && out_rdy;
    end else begin : g_one
        assign in_rdy        = !bus.flush_i && !rst_i && out_rdy;
        assign s_vld         = bus.in_valid_i;
        assign s_eq          = in_eq;
        assign s_lt          = in_lt;
        assign s_ltu         = in_ltu;
        assign s_is_b        = bus.is_b_type_i;
        assign s_pred_taken  = bus.pred_taken_i;
        assign s_f3          = bus.instr_funct3_i;
        assign s_pc          = bus.pc_i;
        assign s_target      = in_target;
        assign s_pred_target = bus.pred_target_i;
        assign out_load      = bus.in_valid_i && in_rdy;
    end

    logic            taken, mispred, misalign, redirect;
    logic [XLEN-1:0] pc4, rpc;

    always_comb begin
        taken = 1'b0;
        if (s_is_b) begin
            case (s_f3)
                3'b000:  taken = s_eq;
                3'b001:  taken = !s_eq;
                3'b100:  taken = s_lt;
                3'b101:  taken = !s_lt;
                3'b110:  taken = s_ltu;
                3'b111:  taken = !s_ltu;
                default: taken = 1'b0;
            endcase
        end
    end

    assign pc4      = s_pc + XLEN'(4);
    assign misalign = taken && (s_target[1:0] != 2'b00);
    assign mispred  = (taken != s_pred_taken) || (taken && (s_target != s_pred_target));
    // A misaligned taken target traps instead of redirecting.
    assign redirect = mispred && !misalign;
    assign rpc      = taken ? s_target : pc4;

    logic            out_taken, out_redirect, out_misalign, out_is_b;
    logic [XLEN-1:0] out_rpc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_vld      <= 1'b0;
            out_taken    <= 1'b0;
            out_redirect <= 1'b0;
            out_misalign <= 1'b0;
            out_is_b     <= 1'b0;
            out_rpc      <= '0;
        end else begin
            if (bus.flush_i)
                out_vld <= 1'b0;
            else if (out_rdy)
                out_vld <= s_vld;
            if (out_load) begin
                out_taken    <= taken;
                out_redirect <= redirect;
                out_misalign <= misalign;
                out_is_b     <= s_is_b;
                out_rpc      <= rpc;
            end
        end
    end

    logic             out_fire;
    logic [CNT_W-1:0] branch_cnt, mispred_cnt;
    assign out_fire = out_vld && bus.out_ready_i;

    // Counters saturate; a clear in the same cycle as an increment wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (bus.cnt_clr_i) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (out_fire) begin
            if (out_is_b && (branch_cnt != '1))
                branch_cnt <= branch_cnt + CNT_W'(1);
            if (out_redirect && (mispred_cnt != '1))
                mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready_o     = in_rdy;
    assign bus.out_valid_o    = out_vld;
    assign bus.branch_taken_o = out_taken;
    assign bus.redirect_o     = out_redirect;
    assign bus.redirect_pc_o  = out_rpc;
    assign bus.misalign_o     = out_misalign;
    assign bus.branch_cnt_o   = branch_cnt;
    assign bus.mispred_cnt_o  = mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: d1 is STAGES=1 with 4-bit counters, d2 is STAGES=2 with 32-bit counters.
module tb_branch_resolve_unit;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(64), .CNT_W(4))  b1 ();
    branch_resolve_unit_if #(.XLEN(64), .CNT_W(32)) b2 ();

    branch_resolve_unit #(.XLEN(64), .STAGES(1), .CNT_W(4))  d1 (.clk_i(clk), .rst_i(rst), .bus(b1));
    branch_resolve_unit #(.XLEN(64), .STAGES(2), .CNT_W(32)) d2 (.clk_i(clk), .rst_i(rst), .bus(b2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic set1(input logic [63:0] a, input logic [63:0] b, input logic [63:0] pc,
                        input logic [63:0] imm, input logic isb, input logic [2:0] f3,
                        input logic pt, input logic [63:0] ptgt);
        b1.opr_a_i = a; b1.opr_b_i = b; b1.pc_i = pc; b1.imm_i = imm;
        b1.is_b_type_i = isb; b1.instr_funct3_i = f3;
        b1.pred_taken_i = pt; b1.pred_target_i = ptgt; b1.in_valid_i = 1'b1;
    endtask

    task automatic set2(input logic [63:0] a, input logic [63:0] b, input logic [63:0] pc,
                        input logic [63:0] imm, input logic isb, input logic [2:0] f3,
                        input logic pt, input logic [63:0] ptgt);
        b2.opr_a_i = a; b2.opr_b_i = b; b2.pc_i = pc; b2.imm_i = imm;
        b2.is_b_type_i = isb; b2.instr_funct3_i = f3;
        b2.pred_taken_i = pt; b2.pred_target_i = ptgt; b2.in_valid_i = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge where the d1 result is visible.
    task automatic issue1(input logic [63:0] a, input logic [63:0] b, input logic [63:0] pc,
                          input logic [63:0] imm, input logic isb, input logic [2:0] f3,
                          input logic pt, input logic [63:0] ptgt);
        set1(a, b, pc, imm, isb, f3, pt, ptgt);
        @(negedge clk);
        b1.in_valid_i = 1'b0;
    endtask

    task automatic step1(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] pc, input logic [63:0] imm, input logic isb,
                         input logic [2:0] f3, input logic pt, input logic [63:0] ptgt,
                         input logic etk, input logic erd, input logic [63:0] erpc,
                         input logic emis, input logic [3:0] ebc, input logic [3:0] emc);
        issue1(a, b, pc, imm, isb, f3, pt, ptgt);
        chk({tag, "_valid"}, b1.out_valid_o, 1'b1);
        chk({tag, "_taken"}, b1.branch_taken_o, etk);
        chk({tag, "_redirect"}, b1.redirect_o, erd);
        chk({tag, "_rpc"}, b1.redirect_pc_o, erpc);
        chk({tag, "_misalign"}, b1.misalign_o, emis);
        @(negedge clk);
        chk({tag, "_bcnt"}, b1.branch_cnt_o, ebc);
        chk({tag, "_mcnt"}, b1.mispred_cnt_o, emc);
    endtask

    logic [63:0] sa[10], sb[10], spt[10], erpc[10];
    logic [2:0]  sf[10];
    logic        sp[10], etk[10], erd[10];
    int          acc[10];
    logic [7:0]  lf;
    int          j, k, cyc;
    localparam logic [63:0] M2 = 64'hFFFF_FFFF_FFFF_FFFE;
    localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        sa   = '{64'd5, 64'd5, M2, M2, M2, M2, 64'd3, 64'd3, 64'd0, 64'd1};
        sb   = '{64'd5, 64'd5, 64'd3, 64'd3, 64'd3, 64'd3, M2, 64'd3, 64'd1, 64'd2};
        sf   = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b100, 3'b101, 3'b110, 3'b000};
        sp   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        spt  = '{64'h0, 64'h0, 64'h4040, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h40A0, 64'h0};
        etk  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        erd  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        erpc = '{64'h4020, 64'h4014, 64'h4040, 64'h4034, 64'h4044,
                 64'h4070, 64'h4064, 64'h4090, 64'h40A0, 64'h4094};

        rst = 1'b1;
        set1(0, 0, 0, 0, 0, 3'b000, 0, 0); b1.in_valid_i = 1'b0;
        set2(0, 0, 0, 0, 0, 3'b000, 0, 0); b2.in_valid_i = 1'b0;
        b1.out_ready_i = 1'b1; b1.flush_i = 1'b0; b1.cnt_clr_i = 1'b0;
        b2.out_ready_i = 1'b1; b2.flush_i = 1'b0; b2.cnt_clr_i = 1'b0;

        #12;
        chk("rst_d1_valid", b1.out_valid_o, 1'b0);
        chk("rst_d1_ready", b1.in_ready_o, 1'b0);
        chk("rst_d1_rpc", b1.redirect_pc_o, 64'h0);
        chk("rst_d1_bcnt", b1.branch_cnt_o, 4'h0);
        chk("rst_d2_valid", b2.out_valid_o, 1'b0);
        chk("rst_d2_ready", b2.in_ready_o, 1'b0);
        chk("rst_d2_mcnt", b2.mispred_cnt_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("idle_d1_ready", b1.in_ready_o, 1'b1);

        // STAGES=1 directed vectors; counter values are cumulative.
        step1("blt",   M1, 64'd1, 64'h2000, 64'h40, 1, 3'b100, 1, 64'h2040, 1, 0, 64'h2040, 0, 4'd1, 4'd0);
        step1("bltu",  M1, 64'd1, 64'h2000, 64'h40, 1, 3'b110, 1, 64'h2040, 0, 1, 64'h2004, 0, 4'd2, 4'd1);
        step1("beq",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8,
              1, 3'b000, 0, 64'h0, 1, 1, 64'hFF8, 0, 4'd3, 4'd2);
        step1("bge",   M1, 64'd1, 64'h3000, 64'h100, 1, 3'b101, 0, 64'h0, 0, 0, 64'h3004, 0, 4'd4, 4'd2);
        step1("undef", 64'd7, 64'd7, 64'h3100, 64'h8, 1, 3'b010, 0, 64'h0, 0, 0, 64'h3104, 0, 4'd5, 4'd2);
        step1("nonbr", 64'd7, 64'd7, 64'h3200, 64'h8, 0, 3'b000, 1, 64'h3208, 0, 1, 64'h3204, 0, 4'd5, 4'd3);
        step1("bne_tgt", 64'd1, 64'd2, 64'h3300, 64'h10, 1, 3'b001, 1, 64'h3314, 1, 1, 64'h3310, 0, 4'd6, 4'd4);
        step1("misal", 64'd0, 64'd0, 64'h1000, 64'h2, 1, 3'b000, 0, 64'h0, 1, 0, 64'h1002, 1, 4'd7, 4'd4);
        step1("wrap",  64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0, 3'b000, 1, 64'h0, 0, 1, 64'h0, 0, 4'd7, 4'd5);

        // Ten back-to-back mispredicts drive both 4-bit counters into saturation.
        for (int i = 0; i < 10; i++) begin
            set1(64'd1, 64'd2, 64'h5000, 64'h8, 1, 3'b000, 1, 64'h0);
            @(negedge clk);
        end
        b1.in_valid_i = 1'b0;
        @(negedge clk);
        chk("sat_bcnt", b1.branch_cnt_o, 4'd15);
        chk("sat_mcnt", b1.mispred_cnt_o, 4'd15);
        step1("sat16", 64'd1, 64'd2, 64'h5000, 64'h8, 1, 3'b000, 1, 64'h0, 0, 1, 64'h5004, 0, 4'd15, 4'd15);

        issue1(64'd1, 64'd2, 64'h5000, 64'h8, 1, 3'b000, 1, 64'h0);
        b1.cnt_clr_i = 1'b1;
        @(negedge clk);
        b1.cnt_clr_i = 1'b0;
        chk("clr_bcnt", b1.branch_cnt_o, 4'd0);
        chk("clr_mcnt", b1.mispred_cnt_o, 4'd0);
        step1("postclr", 64'd1, 64'd2, 64'h5000, 64'h8, 1, 3'b000, 1, 64'h0, 0, 1, 64'h5004, 0, 4'd1, 4'd1);

        // Output hold while the consumer stalls.
        b1.out_ready_i = 1'b0;
        issue1(64'd1, 64'd2, 64'h6000, 64'h20, 1, 3'b001, 0, 64'h0);
        chk("hold_valid0", b1.out_valid_o, 1'b1);
        chk("hold_ready0", b1.in_ready_o, 1'b0);
        @(negedge clk);
        chk("hold_valid1", b1.out_valid_o, 1'b1);
        chk("hold_rpc1", b1.redirect_pc_o, 64'h6020);
        chk("hold_redir1", b1.redirect_o, 1'b1);
        chk("hold_bcnt", b1.branch_cnt_o, 4'd1);
        b1.out_ready_i = 1'b1;
        #1 chk("hold_ready_comb", b1.in_ready_o, 1'b1);
        @(negedge clk);
        chk("hold_drain", b1.out_valid_o, 1'b0);
        chk("hold_bcnt2", b1.branch_cnt_o, 4'd2);
        chk("hold_mcnt2", b1.mispred_cnt_o, 4'd2);

        // STAGES=2 stream with pseudo-random consumer stalls.
        lf = 8'hA5; j = 0; k = 0; cyc = 0;
        while (k < 10 && cyc < 300) begin
            lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
            b2.out_ready_i = lf[0] | lf[2];
            if (j < 10)
                set2(sa[j], sb[j], 64'h4000 + 64'(16 * j), 64'h20, 1, sf[j], sp[j], spt[j]);
            else
                b2.in_valid_i = 1'b0;
            #1;
            if (b2.out_valid_o) begin
                chk("stream_taken", b2.branch_taken_o, etk[k]);
                chk("stream_redirect", b2.redirect_o, erd[k]);
                chk("stream_rpc", b2.redirect_pc_o, erpc[k]);
                if (b2.out_ready_i) begin
                    chk("stream_latency", (cyc - acc[k] >= 2), 1'b1);
                    k++;
                end
            end
            if (b2.in_valid_i && b2.in_ready_o) begin
                acc[j] = cyc;
                j++;
            end
            @(negedge clk);
            cyc++;
        end
        b2.in_valid_i = 1'b0;
        b2.out_ready_i = 1'b1;
        chk("stream_done", k, 10);
        chk("stream_bcnt", b2.branch_cnt_o, 32'd10);
        chk("stream_mcnt", b2.mispred_cnt_o, 32'd4);
        @(negedge clk);
        chk("stream_nodup", b2.out_valid_o, 1'b0);

        // Flush with two entries in flight and the consumer stalled.
        b2.out_ready_i = 1'b0;
        set2(sa[0], sb[0], 64'h4000, 64'h20, 1, sf[0], sp[0], spt[0]);
        @(negedge clk);
        set2(sa[1], sb[1], 64'h4010, 64'h20, 1, sf[1], sp[1], spt[1]);
        #1 chk("fl_ready_pre", b2.in_ready_o, 1'b1);
        @(negedge clk);
        b2.in_valid_i = 1'b0;
        chk("fl_inflight", b2.out_valid_o, 1'b1);
        b2.flush_i = 1'b1;
        set2(sa[2], sb[2], 64'h4020, 64'h20, 1, sf[2], sp[2], spt[2]);
        #1 chk("fl_ready", b2.in_ready_o, 1'b0);
        @(negedge clk);
        b2.flush_i = 1'b0;
        b2.in_valid_i = 1'b0;
        chk("fl_valid", b2.out_valid_o, 1'b0);
        chk("fl_bcnt", b2.branch_cnt_o, 32'd10);
        chk("fl_mcnt", b2.mispred_cnt_o, 32'd4);
        b2.out_ready_i = 1'b1;
        @(negedge clk);
        chk("fl_empty", b2.out_valid_o, 1'b0);
        chk("fl_bcnt2", b2.branch_cnt_o, 32'd10);

        // Asynchronous reset mid-operation.
        b1.out_ready_i = 1'b0;
        issue1(64'd1, 64'd2, 64'h6000, 64'h20, 1, 3'b001, 0, 64'h0);
        chk("ar_pre_valid", b1.out_valid_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", b1.out_valid_o, 1'b0);
        chk("ar_rpc", b1.redirect_pc_o, 64'h0);
        chk("ar_taken", b1.branch_taken_o, 1'b0);
        chk("ar_redirect", b1.redirect_o, 1'b0);
        chk("ar_bcnt", b1.branch_cnt_o, 4'd0);
        chk("ar_mcnt", b1.mispred_cnt_o, 4'd0);
        chk("ar_ready", b1.in_ready_o, 1'b0);
        chk("ar_d2_bcnt", b2.branch_cnt_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Pipelined, parametrised branch resolution stage for the execute path. It evaluates RISC-V conditional branches (signed and unsigned, full XLEN), computes the branch target, and checks the outcome against the front-end prediction. On a mispredict it produces a redirect PC. It uses valid/ready handshakes on both sides, supports a pipeline flush, and keeps saturating branch and mispredict statistics counters.

## Interface
- XLEN, 64: operand and PC width (32 or 64)
- STAGES, 1: pipeline depth, 1 or 2; any other value is an elaboration error
- CNT_W, 32: statistics counter width
- clk_i  in  1  clock; one clock domain, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- in_valid_i  in  1  request valid
- in_ready_o  out  1  unit can accept a request this cycle
- opr_a_i, opr_b_i  in  XLEN  rs1/rs2 values
- pc_i  in  XLEN  branch PC
- imm_i  in  XLEN  sign-extended B-immediate
- is_b_type_i  in  1  request is a conditional branch
- instr_funct3_i  in  3  BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111
- pred_taken_i  in  1  front-end predicted taken
- pred_target_i  in  XLEN  front-end predicted target
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- branch_taken_o  out  1  resolved direction
- redirect_o  out  1  mispredict; fetch must restart at redirect_pc_o
- redirect_pc_o  out  XLEN  correct next PC
- misalign_o  out  1  taken target not 4-byte aligned
- flush_i  in  1  kill all in-flight requests
- cnt_clr_i  in  1  synchronous clear of both counters
- branch_cnt_o  out  CNT_W  resolved b-type branches
- mispred_cnt_o  out  CNT_W  redirects issued

## Operation
- Direction is decided by funct3:
  - EQ/NE compare all XLEN bits.
  - LT/GE use a true two's-complement signed compare over the full XLEN.
  - LTU/GEU use an unsigned compare.
  - Undefined funct3 gives not-taken.
  - `branch_taken_o` is 0 whenever is_b_type is 0.
- Target is `pc + imm` modulo 2^XLEN. The fall-through PC is `pc + 4` modulo 2^XLEN.
- `redirect_pc_o` = taken ? target : pc+4.
- Mispredict condition: `(taken != pred_taken) || (taken && target != pred_target)`.
- A non-branch request with pred_taken=1 is a mispredict, with redirect to pc+4.
- `misalign_o` = taken && target[1:0] != 0.
  - When misalign_o is 1, redirect_o is forced to 0 (the trap path owns recovery).
  - The mispredict counter does not increment in that case.
- Counters increment on an output handshake (out_valid_o && out_ready_i):
  - branch_cnt increments when the entry is b-type.
  - mispred_cnt increments when redirect_o is 1.
  - Both saturate at all-ones and never wrap.
  - If cnt_clr_i and an increment occur in the same cycle, clear wins and the counter becomes 0.
- Flush:
  - flush_i clears every stage valid bit, including the output register, at the next edge.
  - in_valid_i is ignored during a flush cycle (in_ready_o is 0).
  - An output handshake completing in the flush cycle is a valid transfer and is counted.

## Timing
- Reset: all stage valids 0, out_valid_o 0, every data output 0, both counters 0, in_ready_o 0 while rst_i is high.
- Latency: a request accepted at edge N presents out_valid_o after edge N+STAGES-1, i.e. in the cycle following the accept edge when STAGES=1.
  - STAGES=1: compare, target and mispredict logic sit before the output register.
  - STAGES=2: stage A registers the operands, the eq/lt/ltu compare bits and the target; stage B registers the final outputs.
- Throughput: one request per cycle when out_ready_i is held at 1.
- Backpressure:
  - Each stage advances when it is empty or the stage downstream advances.
  - in_ready_o = !flush_i && !rst_i && (stage0 empty || stage0 advances). This is combinational from out_ready_i; no bubble is inserted.
- Hold rule: while out_valid_o && !out_ready_i, all result outputs hold stable.
- Counter outputs are registered; an increment is visible the cycle after the handshake.
- Reset asserted mid-operation discards all entries immediately (asynchronous) and also clears the counters.

## Test plan
- XLEN=64, STAGES=1: BLT with a=0xFFFF_FFFF_FFFF_FFFF (-1), b=1, pred_taken=1, target correct -> taken=1, redirect=0, branch_cnt=1. Repeat with BLTU -> taken=0, redirect=1, redirect_pc=pc+4.
- BEQ, a=b=0x8000_0000_0000_0000, pc=0x1000, imm=-8, pred_taken=0 -> taken=1, redirect=1, redirect_pc=0xFF8, mispred_cnt=1.
- STAGES=2, a 10-request back-to-back stream with out_ready_i random (seed fixed) -> results in order, none dropped or duplicated, each latency ≥2, outputs stable while stalled.
- Flush injected with 2 entries in flight and out_ready_i=0 -> out_valid_o=0 the next cycle, counters unchanged, in_ready_o=0 in the flush cycle.
- Counter preloaded near max (CNT_W=4, 15 mispredicts) -> stays at 15 after a 16th. cnt_clr_i coinciding with an increment -> 0.
- Taken branch to target 0x1002 -> misalign_o=1, redirect_o=0, mispred_cnt unchanged. Async rst_i pulse mid-stream -> all outputs 0 immediately.
